uart_tx_core: RTL and testbench
===============================

# uart_tx_core

UART transmitter for the serial link. It accepts one byte per valid/ready handshake and serializes it on `tx` as start, 8 data bits LSB-first, optional parity, then one stop bit. Bit timing comes from an internal divider driven by the same 2-bit `baud_rate` select as the receive-side baud generator. It sits between the host-side byte source and the TX pad, and is the transmit counterpart of the receive path.

## Interface
Parameters:
- `DIV2400`, default 20833: clk cycles per bit at `baud_rate`=2'b00 (50 MHz clk).
- `DIV4800`, default 10417: clk cycles per bit at 2'b01.
- `DIV9600`, default 5208: clk cycles per bit at 2'b10. Also used for any undefined select value.
- `DIV19200`, default 2604: clk cycles per bit at 2'b11.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `baud_rate` input 2: baud select; 00=2400, 01=4800, 10=9600, 11=19200.
- `parity_en` input 1: 1 inserts a parity bit after the data bits.
- `parity_odd` input 1: 1 selects odd parity, 0 selects even parity.
- `tx_data` input 8: byte to send.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: block can accept a byte.
- `tx` output 1: serial line, idle high.
- `tx_busy` output 1: a frame is in progress.
- `tx_done` output 1: one-cycle pulse after the stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. All registers are 15 bits wide or narrower.
- Outputs at reset: state=IDLE, `tx`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=1, bit counter=0, divider=0.
- `tx_ready` = (state==IDLE). It is combinational from the state register.
- Accept condition: `tx_valid && tx_ready` on a rising clk edge. On accept, the block:
  - latches `tx_data` into the shift register;
  - latches `parity_en`, `parity_odd` and the divisor selected by `baud_rate`;
  - computes the parity bit from the latched byte: even = ^data, odd = ~^data.
- Changes to `baud_rate`, `parity_en` or `parity_odd` after accept do not affect the frame in flight.
- Divider: counts 0..DIV-1. At DIV-1 it wraps to 0 and advances one bit. It is cleared on accept.
- Per-state line level:
  - START: `tx`=0.
  - DATA: `tx` = shift[0]. The register shifts right once per bit; the 3-bit index runs 0..7.
  - PARITY: `tx` = latched parity bit.
  - STOP: `tx`=1.
  - IDLE: `tx`=1.
- Transitions, each taken at divider wrap:
  - START -> DATA.
  - DATA(index 7) -> PARITY if parity is enabled, otherwise -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE, with `tx_done` asserted for that one next cycle.
- `tx_busy` = (state != IDLE). It is registered alongside the state.
- `tx` is driven from a register, so the line carries no glitches.
- `tx_valid` while not ready: the byte is ignored. The source must hold `tx_valid` until it sees ready.

## Timing
- Accept at cycle 0. `tx` falls at cycle 1. Each bit lasts exactly DIV cycles.
- The start bit occupies cycles 1..DIV. Data bit k occupies cycles (k+1)·DIV+1 .. (k+2)·DIV.
- Frame length after accept: 10·DIV cycles without parity, 11·DIV with parity.
- `tx_done` goes high in the first IDLE cycle, which is also the first cycle `tx_ready`=1.
- Back-to-back frames: a byte accepted in the `tx_done` cycle starts its start bit on the next cycle. The minimum gap between frames is 1 idle-high cycle.
- Reset mid-frame: `tx` returns to 1 immediately and asynchronously, and all state clears. No `tx_done` is generated.
- Simultaneous `tx_valid` and reset deassertion: the first accept can occur on the first clk edge with `rst_n`=1.

## Test plan
- Parameters DIV19200=4, `baud_rate`=11, parity off. Send 0xA5. Required:
  - `tx` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1;
  - `tx_done` pulses at cycle 41;
  - `tx_busy` high for cycles 1–40.
- Parity even on 0x07 (three ones): parity bit=1, frame lasts 44 cycles. Parity odd on 0x07: parity bit=0.
- Change `baud_rate` from 11 to 00 mid-frame with DIV2400=16. Required: the current frame keeps 4-cycle bits; the next accepted frame uses 16-cycle bits.
- Hold `tx_valid`=1 with 0x55 then 0xAA across two frames. Required:
  - the second accept occurs in the `tx_done` cycle;
  - exactly 1 idle-high cycle separates the two frames.
- Assert `rst_n`=0 during data bit 3. Required:
  - `tx`=1, `tx_busy`=0, `tx_ready`=1 immediately;
  - no `tx_done` pulse;
  - the next byte transmits correctly.
- Undefined-behavior check with all four `baud_rate` values using small DIVs (16/8/6/4). Required: bit width equals the selected DIV. Pulse `tx_valid` while busy: the byte is ignored.

Source files
------------

// File: rtl/uart_tx_core.sv
// UART transmitter: one byte per valid/ready handshake, sent as start, 8 data bits LSB-first,
// optional parity and one stop bit, with bit timing from a divisor latched at accept.
module uart_tx_core #(
    parameter int DIV2400  = 20833,
    parameter int DIV4800  = 10417,
    parameter int DIV9600  = 5208,
    parameter int DIV19200 = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] baud_rate,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitIdx;
    logic [14:0] r_divCnt;
    logic [14:0] r_divisor;
    logic        r_parityEn;
    logic        r_parityBit;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic        w_bitTick;
    logic        w_txNext;
    logic        w_busyNext;
    logic        w_doneNext;
    logic [14:0] w_divSel;

    assign tx_ready  = (r_state == IDLE);
    assign w_accept  = tx_valid && tx_ready;
    assign w_bitTick = (r_state != IDLE) && (r_divCnt == r_divisor - 15'd1);

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

    // Unlisted select values fall back to the 9600 divisor.
    always_comb begin
        case (baud_rate)
            2'b00:   w_divSel = 15'(DIV2400);
            2'b01:   w_divSel = 15'(DIV4800);
            2'b11:   w_divSel = 15'(DIV19200);
            default: w_divSel = 15'(DIV9600);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_tx    <= w_txNext;
            r_busy  <= w_busyNext;
            r_done  <= w_doneNext;
        end
    end

    // The line level is computed for the upcoming state so tx comes straight from a flop.
    always_comb begin
        w_stateNext = r_state;
        w_txNext    = r_tx;
        w_doneNext  = 1'b0;
        case (r_state)
            IDLE: begin
                w_txNext = 1'b1;
                if (w_accept) begin
                    w_stateNext = START;
                    w_txNext    = 1'b0;
                end
            end
            START: begin
                if (w_bitTick) begin
                    w_stateNext = DATA;
                    w_txNext    = r_shift[0];
                end
            end
            DATA: begin
                if (w_bitTick) begin
                    if (r_bitIdx == 3'd7) begin
                        if (r_parityEn) begin
                            w_stateNext = PARITY;
                            w_txNext    = r_parityBit;
                        end else begin
                            w_stateNext = STOP;
                            w_txNext    = 1'b1;
                        end
                    end else begin
                        w_txNext = r_shift[1];
                    end
                end
            end
            PARITY: begin
                if (w_bitTick) begin
                    w_stateNext = STOP;
                    w_txNext    = 1'b1;
                end
            end
            STOP: begin
                if (w_bitTick) begin
                    w_stateNext = IDLE;
                    w_txNext    = 1'b1;
                    w_doneNext  = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_txNext    = 1'b1;
            end
        endcase
        w_busyNext = (w_stateNext != IDLE);
    end

    // Frame settings are captured at accept so later input changes leave the frame alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= 8'd0;
            r_bitIdx    <= 3'd0;
            r_divCnt    <= 15'd0;
            r_divisor   <= 15'd0;
            r_parityEn  <= 1'b0;
            r_parityBit <= 1'b0;
        end else if (w_accept) begin
            r_shift     <= tx_data;
            r_bitIdx    <= 3'd0;
            r_divCnt    <= 15'd0;
            r_divisor   <= w_divSel;
            r_parityEn  <= parity_en;
            r_parityBit <= parity_odd ? ~^tx_data : ^tx_data;
        end else if (r_state != IDLE) begin
            if (w_bitTick) begin
                r_divCnt <= 15'd0;
                if (r_state == DATA) begin
                    r_shift  <= r_shift >> 1;
                    r_bitIdx <= r_bitIdx + 3'd1;
                end
            end else begin
                r_divCnt <= r_divCnt + 15'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core with small divisors (16/8/6/4) so whole frames are
// captured cycle by cycle and compared against a bit-position model of the frame.
module tb_uart_tx_core;

    logic       clk;
    logic       rst_n;
    logic [1:0] baud_rate;
    logic       parity_en;
    logic       parity_odd;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int total = 0;
    int bad   = 0;

    logic txLog    [1:255];
    logic busyLog  [1:255];
    logic doneLog  [1:255];
    logic readyLog [1:255];

    uart_tx_core #(
        .DIV2400(16),
        .DIV4800(8),
        .DIV9600(6),
        .DIV19200(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .baud_rate(baud_rate),
        .parity_en(parity_en),
        .parity_odd(parity_odd),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx(tx),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Expected line level c cycles after the accept edge (c=1 is the first start-bit cycle).
    function automatic logic expTx(input logic [7:0] d, input logic par, input logic pbit,
                                   input int div, input int c);
        int b;
        b = (c - 1) / div;
        if (c < 1) return 1'b1;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (par && b == 9) return pbit;
        return 1'b1;
    endfunction

    task automatic sendByte(input logic [7:0] d, input bit hold);
        int k;
        k = 0;
        while (tx_ready !== 1'b1 && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (k >= 1000) begin
            bad++;
            $display("[TB] FAIL send_ready_timeout got=%b want=1", tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    // Records outputs for n cycles; optional mid-frame baud change, busy-time pulse, valid drop.
    task automatic capture(input int n, input int chgCycle, input logic [1:0] chgBaud,
                           input int pulseCycle, input int dropCycle);
        for (int c = 1; c <= n; c++) begin
            txLog[c]    = tx;
            busyLog[c]  = tx_busy;
            doneLog[c]  = tx_done;
            readyLog[c] = tx_ready;
            if (chgCycle > 0 && c == chgCycle) baud_rate = chgBaud;
            if (pulseCycle > 0 && c == pulseCycle) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            if (pulseCycle > 0 && c == pulseCycle + 1) tx_valid = 1'b0;
            if (dropCycle > 0 && c == dropCycle) tx_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx !== 1'b1)       begin bad++; $display("[TB] FAIL reset_tx got=%b want=1", tx); end
        total++; if (tx_busy !== 1'b0)  begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", tx_busy); end
        total++; if (tx_done !== 1'b0)  begin bad++; $display("[TB] FAIL reset_done got=%b want=0", tx_done); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", tx_ready); end
        // valid rises together with reset release; the first edge must accept it
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        capture(42, 0, 2'b11, 0, 0);
        for (int c = 1; c <= 42; c++) begin
            total++;
            if (txLog[c] !== expTx(8'h81, 1'b0, 1'b0, 4, c)) begin
                bad++; $display("[TB] FAIL first_accept_tx c=%0d got=%b want=%b", c, txLog[c], expTx(8'h81, 1'b0, 1'b0, 4, c));
            end
            total++;
            if (doneLog[c] !== (c == 41)) begin
                bad++; $display("[TB] FAIL first_accept_done c=%0d got=%b want=%b", c, doneLog[c], (c == 41));
            end
        end
    endtask

    task automatic test_basic;
        sendByte(8'hA5, 1'b0);
        capture(42, 0, 2'b11, 0, 0);
        for (int c = 1; c <= 42; c++) begin
            total++;
            if (txLog[c] !== expTx(8'hA5, 1'b0, 1'b0, 4, c)) begin
                bad++; $display("[TB] FAIL basic_tx c=%0d got=%b want=%b", c, txLog[c], expTx(8'hA5, 1'b0, 1'b0, 4, c));
            end
            total++;
            if (doneLog[c] !== (c == 41)) begin
                bad++; $display("[TB] FAIL basic_done c=%0d got=%b want=%b", c, doneLog[c], (c == 41));
            end
            total++;
            if (busyLog[c] !== (c <= 40)) begin
                bad++; $display("[TB] FAIL basic_busy c=%0d got=%b want=%b", c, busyLog[c], (c <= 40));
            end
            total++;
            if (readyLog[c] !== (c >= 41)) begin
                bad++; $display("[TB] FAIL basic_ready c=%0d got=%b want=%b", c, readyLog[c], (c >= 41));
            end
        end
    endtask

    task automatic test_parity;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        sendByte(8'h07, 1'b0);
        capture(46, 0, 2'b11, 0, 0);
        for (int c = 1; c <= 46; c++) begin
            total++;
            if (txLog[c] !== expTx(8'h07, 1'b1, 1'b1, 4, c)) begin
                bad++; $display("[TB] FAIL parity_even_tx c=%0d got=%b want=%b", c, txLog[c], expTx(8'h07, 1'b1, 1'b1, 4, c));
            end
            total++;
            if (doneLog[c] !== (c == 45)) begin
                bad++; $display("[TB] FAIL parity_even_done c=%0d got=%b want=%b", c, doneLog[c], (c == 45));
            end
            total++;
            if (busyLog[c] !== (c <= 44)) begin
                bad++; $display("[TB] FAIL parity_even_busy c=%0d got=%b want=%b", c, busyLog[c], (c <= 44));
            end
        end
        parity_odd = 1'b1;
        sendByte(8'h07, 1'b0);
        capture(46, 0, 2'b11, 0, 0);
        for (int c = 1; c <= 46; c++) begin
            total++;
            if (txLog[c] !== expTx(8'h07, 1'b1, 1'b0, 4, c)) begin
                bad++; $display("[TB] FAIL parity_odd_tx c=%0d got=%b want=%b", c, txLog[c], expTx(8'h07, 1'b1, 1'b0, 4, c));
            end
            total++;
            if (doneLog[c] !== (c == 45)) begin
                bad++; $display("[TB] FAIL parity_odd_done c=%0d got=%b want=%b", c, doneLog[c], (c == 45));
            end
        end
        parity_en  = 1'b0;
        parity_odd = 1'b0;
    endtask

    task automatic test_baud_change;
        baud_rate = 2'b11;
        sendByte(8'h3C, 1'b0);
        capture(42, 6, 2'b00, 0, 0);
        for (int c = 1; c <= 42; c++) begin
            total++;
            if (txLog[c] !== expTx(8'h3C, 1'b0, 1'b0, 4, c)) begin
                bad++; $display("[TB] FAIL baudchg_cur_tx c=%0d got=%b want=%b", c, txLog[c], expTx(8'h3C, 1'b0, 1'b0, 4, c));
            end
            total++;
            if (doneLog[c] !== (c == 41)) begin
                bad++; $display("[TB] FAIL baudchg_cur_done c=%0d got=%b want=%b", c, doneLog[c], (c == 41));
            end
        end
        sendByte(8'h3C, 1'b0);
        capture(162, 0, 2'b00, 0, 0);
        for (int c = 1; c <= 162; c++) begin
            total++;
            if (txLog[c] !== expTx(8'h3C, 1'b0, 1'b0, 16, c)) begin
                bad++; $display("[TB] FAIL baudchg_next_tx c=%0d got=%b want=%b", c, txLog[c], expTx(8'h3C, 1'b0, 1'b0, 16, c));
            end
            total++;
            if (doneLog[c] !== (c == 161)) begin
                bad++; $display("[TB] FAIL baudchg_next_done c=%0d got=%b want=%b", c, doneLog[c], (c == 161));
            end
        end
        baud_rate = 2'b11;
    endtask

    task automatic test_back_to_back;
        logic want;
        baud_rate = 2'b11;
        sendByte(8'h55, 1'b1);
        tx_data = 8'hAA;
        capture(82, 0, 2'b11, 0, 82);
        for (int c = 1; c <= 82; c++) begin
            if (c <= 40)      want = expTx(8'h55, 1'b0, 1'b0, 4, c);
            else if (c == 41) want = 1'b1;
            else              want = expTx(8'hAA, 1'b0, 1'b0, 4, c - 41);
            total++;
            if (txLog[c] !== want) begin
                bad++; $display("[TB] FAIL b2b_tx c=%0d got=%b want=%b", c, txLog[c], want);
            end
            total++;
            if (doneLog[c] !== (c == 41 || c == 82)) begin
                bad++; $display("[TB] FAIL b2b_done c=%0d got=%b want=%b", c, doneLog[c], (c == 41 || c == 82));
            end
            total++;
            if (readyLog[c] !== (c == 41 || c == 82)) begin
                bad++; $display("[TB] FAIL b2b_ready c=%0d got=%b want=%b", c, readyLog[c], (c == 41 || c == 82));
            end
        end
    endtask

    task automatic test_reset_midframe;
        baud_rate = 2'b11;
        sendByte(8'hC3, 1'b0);
        capture(17, 0, 2'b11, 0, 0);
        for (int c = 1; c <= 17; c++) begin
            total++;
            if (txLog[c] !== expTx(8'hC3, 1'b0, 1'b0, 4, c)) begin
                bad++; $display("[TB] FAIL rstmid_pre_tx c=%0d got=%b want=%b", c, txLog[c], expTx(8'hC3, 1'b0, 1'b0, 4, c));
            end
        end
        // now in cycle 18, inside data bit 3; reset lands between clock edges
        rst_n = 1'b0;
        #1;
        total++; if (tx !== 1'b1)       begin bad++; $display("[TB] FAIL rstmid_tx got=%b want=1", tx); end
        total++; if (tx_busy !== 1'b0)  begin bad++; $display("[TB] FAIL rstmid_busy got=%b want=0", tx_busy); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_ready got=%b want=1", tx_ready); end
        total++; if (tx_done !== 1'b0)  begin bad++; $display("[TB] FAIL rstmid_done got=%b want=0", tx_done); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            total++;
            if (tx_done !== 1'b0 || tx !== 1'b1) begin
                bad++; $display("[TB] FAIL rstmid_quiet c=%0d got=done%b/tx%b want=done0/tx1", c, tx_done, tx);
            end
            @(posedge clk); #1;
        end
        sendByte(8'h96, 1'b0);
        capture(42, 0, 2'b11, 0, 0);
        for (int c = 1; c <= 42; c++) begin
            total++;
            if (txLog[c] !== expTx(8'h96, 1'b0, 1'b0, 4, c)) begin
                bad++; $display("[TB] FAIL rstmid_next_tx c=%0d got=%b want=%b", c, txLog[c], expTx(8'h96, 1'b0, 1'b0, 4, c));
            end
            total++;
            if (doneLog[c] !== (c == 41)) begin
                bad++; $display("[TB] FAIL rstmid_next_done c=%0d got=%b want=%b", c, doneLog[c], (c == 41));
            end
        end
    endtask

    task automatic test_all_baud;
        int divTab [4];
        logic [7:0] dataTab [4];
        int div;
        int n;
        divTab  = '{16, 8, 6, 4};
        dataTab = '{8'h5A, 8'h1E, 8'hE1, 8'h69};
        for (int s = 0; s < 4; s++) begin
            baud_rate = 2'(s);
            div = divTab[s];
            n   = 10 * div + 2;
            sendByte(dataTab[s], 1'b0);
            capture(n, 0, 2'b00, 10, 0);
            for (int c = 1; c <= n; c++) begin
                total++;
                if (txLog[c] !== expTx(dataTab[s], 1'b0, 1'b0, div, c)) begin
                    bad++; $display("[TB] FAIL allbaud_tx sel=%0d c=%0d got=%b want=%b", s, c, txLog[c], expTx(dataTab[s], 1'b0, 1'b0, div, c));
                end
                total++;
                if (doneLog[c] !== (c == 10 * div + 1)) begin
                    bad++; $display("[TB] FAIL allbaud_done sel=%0d c=%0d got=%b want=%b", s, c, doneLog[c], (c == 10 * div + 1));
                end
            end
            for (int k = 0; k < 5; k++) begin
                total++;
                if (tx_busy !== 1'b0 || tx !== 1'b1) begin
                    bad++; $display("[TB] FAIL allbaud_idle sel=%0d k=%0d got=busy%b/tx%b want=busy0/tx1", s, k, tx_busy, tx);
                end
                @(posedge clk); #1;
            end
        end
        baud_rate = 2'b11;
    endtask

    initial begin
        rst_n      = 1'b0;
        baud_rate  = 2'b11;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        test_reset;
        test_basic;
        test_parity;
        test_baud_change;
        test_back_to_back;
        test_reset_midframe;
        test_all_baud;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
